// File: rtl/pl_bram_wr_s00_axi.sv
// AXI4-Lite register block (CTRL/BASE/LEN/SEED) that fills a PL BRAM write port
// with an incrementing data pattern, one word per clock.
module pl_bram_wr_s00_axi #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int C_BRAM_ADDR_WIDTH  = 15
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic [C_BRAM_ADDR_WIDTH-1:0]      bram_addr,
   output logic [31:0]                       bram_din,
   output logic                              bram_en,
   output logic [3:0]                        bram_we,
   output logic                              done_irq
);

   localparam logic [C_BRAM_ADDR_WIDTH-1:0] ADDR_STEP = C_BRAM_ADDR_WIDTH'(3'd4);

   typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

   state_t                         state_r, state_s;
   logic                           axi_wrdy_r, bvalid_r, arready_r, rvalid_r;
   logic [31:0]                    rdata_r, rd_mux_s;
   logic [31:0]                    base_r, seed_r, base_nx_s, seed_nx_s;
   logic [15:0]                    len_r, len_nx_s, len_w_r, count_r;
   logic                           done_r, irq_r, en_r;
   logic [3:0]                     we_r;
   logic [C_BRAM_ADDR_WIDTH-1:0]   addr_r;
   logic [31:0]                    din_r;
   logic                           wr_hs_s, rd_hs_s, ctrl_wr_s, start_s, clr_s, last_s;
   logic                           unused_s;

   function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      end
      return res;
   endfunction

   assign unused_s  = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   assign wr_hs_s   = axi_wrdy_r & s00_axi_awvalid & s00_axi_wvalid;
   assign rd_hs_s   = arready_r & s00_axi_arvalid;
   assign ctrl_wr_s = wr_hs_s && (s00_axi_awaddr[3:2] == 2'd0) && s00_axi_wstrb[0];
   assign start_s   = ctrl_wr_s && s00_axi_wdata[0];
   assign clr_s     = ctrl_wr_s && s00_axi_wdata[1];
   assign last_s    = (state_r == FILL) && (count_r == len_w_r);

   assign base_nx_s = merge_strb(base_r, s00_axi_wdata, s00_axi_wstrb) & 32'hFFFF_FFFC;
   assign seed_nx_s = merge_strb(seed_r, s00_axi_wdata, s00_axi_wstrb);
   assign len_nx_s  = {s00_axi_wstrb[1] ? s00_axi_wdata[15:8] : len_r[15:8],
                       s00_axi_wstrb[0] ? s00_axi_wdata[7:0]  : len_r[7:0]};

   // Read-data selection; CTRL reports busy, sticky done and the words written so far
   always_comb begin
      rd_mux_s = 32'd0;
      case (s00_axi_araddr[3:2])
         2'd0:    rd_mux_s = {count_r, 14'd0, done_r, (state_r == FILL)};
         2'd1:    rd_mux_s = base_r;
         2'd2:    rd_mux_s = {16'd0, len_r};
         2'd3:    rd_mux_s = seed_r;
         default: rd_mux_s = 32'd0;
      endcase
   end

   // AXI handshakes: ready strobes are one-cycle pulses, responses hold until accepted
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         axi_wrdy_r <= 1'b0;
         bvalid_r   <= 1'b0;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rdata_r    <= 32'd0;
      end else begin
         axi_wrdy_r <= !axi_wrdy_r && s00_axi_awvalid && s00_axi_wvalid && !bvalid_r;
         arready_r  <= !arready_r && s00_axi_arvalid && !rvalid_r;
         if (wr_hs_s) begin
            bvalid_r <= 1'b1;
         end else if (s00_axi_bready) begin
            bvalid_r <= 1'b0;
         end
         if (rd_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_mux_s;
         end else if (s00_axi_rready) begin
            rvalid_r <= 1'b0;
         end
      end
   end

   // Programmable registers; CTRL is action-only and handled by the fill engine
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         base_r <= 32'd0;
         len_r  <= 16'd0;
         seed_r <= 32'd0;
      end else if (wr_hs_s) begin
         case (s00_axi_awaddr[3:2])
            2'd1:    base_r <= base_nx_s;
            2'd2:    len_r  <= len_nx_s;
            2'd3:    seed_r <= seed_nx_s;
            default: ;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s && (len_r != 16'd0)) state_s = FILL;
            else                             state_s = IDLE;
         end
         FILL: begin
            if (last_s) state_s = IDLE;
            else        state_s = FILL;
         end
         default: state_s = IDLE;
      endcase
   end

   // Fill engine: the first beat is issued on the START edge so BRAM sees it next cycle
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         len_w_r <= 16'd0;
         count_r <= 16'd0;
         done_r  <= 1'b0;
         irq_r   <= 1'b0;
         en_r    <= 1'b0;
         we_r    <= 4'h0;
         addr_r  <= '0;
         din_r   <= 32'd0;
      end else begin
         irq_r <= 1'b0;
         case (state_r)
            IDLE: begin
               en_r <= 1'b0;
               we_r <= 4'h0;
               if (start_s) begin
                  len_w_r <= len_r;
                  count_r <= 16'd0;
                  done_r  <= (len_r == 16'd0);
                  irq_r   <= (len_r == 16'd0);
                  if (len_r != 16'd0) begin
                     en_r    <= 1'b1;
                     we_r    <= 4'hF;
                     addr_r  <= base_r[C_BRAM_ADDR_WIDTH-1:0];
                     din_r   <= seed_r;
                     count_r <= 16'd1;
                  end
               end else if (clr_s) begin
                  done_r <= 1'b0;
               end
            end
            FILL: begin
               if (last_s) begin
                  en_r   <= 1'b0;
                  we_r   <= 4'h0;
                  done_r <= 1'b1;
                  irq_r  <= 1'b1;
               end else begin
                  addr_r  <= addr_r + ADDR_STEP;
                  din_r   <= din_r + 32'd1;
                  count_r <= count_r + 16'd1;
               end
            end
            default: begin
               en_r <= 1'b0;
               we_r <= 4'h0;
            end
         endcase
      end
   end

   assign s00_axi_awready = axi_wrdy_r;
   assign s00_axi_wready  = axi_wrdy_r;
   assign s00_axi_bvalid  = bvalid_r;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_arready = arready_r;
   assign s00_axi_rvalid  = rvalid_r;
   assign s00_axi_rdata   = rdata_r;
   assign s00_axi_rresp   = 2'b00;
   assign bram_addr       = addr_r;
   assign bram_din        = din_r;
   assign bram_en         = en_r;
   assign bram_we         = we_r;
   assign done_irq        = irq_r;

endmodule

// File: tb/tb_pl_bram_wr_s00_axi.sv
// Randomized bench for pl_bram_wr_s00_axi: AXI-Lite register traffic and BRAM fills
// compared against a register/fill model kept in the bench.
module tb_pl_bram_wr_s00_axi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awaddr = 4'd0, araddr = 4'd0;
   logic [2:0]  awprot = 3'd0, arprot = 3'd0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wstrb = 4'd0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [14:0] bram_addr;
   logic [31:0] bram_din;
   logic        bram_en, done_irq;
   logic [3:0]  bram_we;

   pl_bram_wr_s00_axi dut (
      .s00_axi_aclk(clk), .s00_axi_areset(rst),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_en(bram_en), .bram_we(bram_we), .done_irq(done_irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int c; logic [14:0] a; logic [31:0] d; logic [3:0] we; } beat_t;
   beat_t beats[$];
   int irq_cnt = 0, irq_cyc = 0;

   // Record every BRAM beat and interrupt pulse with its cycle number
   always @(negedge clk) begin
      if (bram_en) beats.push_back('{cyc, bram_addr, bram_din, bram_we});
      if (done_irq) begin
         irq_cnt++;
         irq_cyc = cyc;
      end
   end

   int n_checks = 0, n_fail = 0;
   logic [31:0] m_base = 32'd0, m_len = 32'd0, m_seed = 32'd0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] strb_mask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit skip_b, output int hs);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
      check_val("aw_handshake", {31'd0, awready && wready}, 32'd1);
      hs = cyc + 1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      if (!skip_b) begin
         n = 0;
         while (!bvalid && n < 20) begin @(negedge clk); n++; end
         bready = 1'b1;
         @(posedge clk); #1;
         bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 20);
      check_val("ar_handshake", {31'd0, arready}, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      d = rdata;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   // Register write that also updates the model (BASE/LEN/SEED only)
   task automatic write_reg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int hs;
      logic [31:0] mk;
      mk = strb_mask(s);
      axi_write(a, d, s, 1'b0, hs);
      case (a[3:2])
         2'd1: m_base = ((m_base & ~mk) | (d & mk)) & 32'hFFFF_FFFC;
         2'd2: m_len  = ((m_len  & ~mk) | (d & mk)) & 32'h0000_FFFF;
         2'd3: m_seed = (m_seed & ~mk) | (d & mk);
         default: ;
      endcase
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(a, d);
      check_val(tag, d, exp);
   endtask

   task automatic fill_start(input logic [31:0] base, input logic [31:0] len, input logic [31:0] seed,
                             input logic [31:0] ctrl, output int hs);
      write_reg(4'h4, base, 4'hF);
      write_reg(4'h8, len, 4'hF);
      write_reg(4'hC, seed, 4'hF);
      beats.delete();
      irq_cnt = 0;
      axi_write(4'h0, ctrl, 4'hF, 1'b0, hs);
   endtask

   task automatic fill_finish(input logic [31:0] base, input logic [31:0] len, input logic [31:0] seed,
                              input int hs);
      int n;
      logic [31:0] ea;
      n = 0;
      while (irq_cnt == 0 && n < int'(len) + 20) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      check_val("irq_count", irq_cnt, 32'd1);
      check_val("irq_cycle", irq_cyc, hs + int'(len));
      check_val("beat_count", beats.size(), len);
      for (int i = 0; i < beats.size() && i < int'(len); i++) begin
         ea = ((base & 32'hFFFF_FFFC) + 32'(4 * i)) & 32'h0000_7FFF;
         check_val("beat_addr", {17'd0, beats[i].a}, ea);
         check_val("beat_data", beats[i].d, seed + 32'(i));
         check_val("beat_we", {28'd0, beats[i].we}, 32'h0000_000F);
         check_val("beat_cycle", beats[i].c, hs + i);
      end
      read_chk("ctrl_after_fill", 4'h0, (len << 16) | 32'h2);
   endtask

   initial begin
      int hs, stall;
      logic [31:0] b, l, s, d;

      // reset state
      repeat (3) @(negedge clk);
      check_val("rst_bram", {27'd0, bram_en, bram_we}, 32'd0);
      check_val("rst_axi", {28'd0, awready, bvalid, arready, rvalid}, 32'd0);
      check_val("rst_irq", {31'd0, done_irq}, 32'd0);
      rst = 1'b0;
      read_chk("rst_ctrl", 4'h0, 32'd0);
      read_chk("rst_base", 4'h4, 32'd0);
      read_chk("rst_len",  4'h8, 32'd0);
      read_chk("rst_seed", 4'hC, 32'd0);

      // plain register access and byte strobes
      axi_write(4'h0, 32'h2, 4'hF, 1'b0, hs);
      write_reg(4'h4, 32'h7, 4'hF);
      write_reg(4'h8, 32'h3, 4'hF);
      write_reg(4'hC, 32'h4, 4'hF);
      check_val("bresp", {30'd0, bresp}, 32'd0);
      read_chk("reg_ctrl", 4'h0, 32'd0);
      read_chk("reg_base", 4'h4, m_base);
      read_chk("reg_len",  4'h8, m_len);
      read_chk("reg_seed", 4'hC, m_seed);
      check_val("rresp", {30'd0, rresp}, 32'd0);
      write_reg(4'hC, 32'hFFFF_FFFF, 4'hF);
      write_reg(4'hC, 32'h1234_5678, 4'b0101);
      read_chk("strb_seed", 4'hC, m_seed);
      write_reg(4'h8, 32'hABCD_1234, 4'hF);
      read_chk("strb_len", 4'h8, m_len);
      write_reg(4'h4, 32'h0000_AB03, 4'b0010);
      read_chk("strb_base", 4'h4, m_base);

      // directed fills: basic, empty, wrap-around
      fill_start(32'h100, 32'd4, 32'hA5A5_0000, 32'h1, hs);
      fill_finish(32'h100, 32'd4, 32'hA5A5_0000, hs);
      fill_start(32'h40, 32'd0, 32'h1, 32'h1, hs);
      fill_finish(32'h40, 32'd0, 32'h1, hs);
      fill_start(32'h7FFC, 32'd2, 32'hFFFF_FFFF, 32'h1, hs);
      fill_finish(32'h7FFC, 32'd2, 32'hFFFF_FFFF, hs);

      // randomized fills
      for (int k = 0; k < 5; k++) begin
         b = $urandom;
         l = $urandom_range(1, 12);
         s = $urandom;
         fill_start(b, l, s, 32'h1, hs);
         fill_finish(b, l, s, hs);
         read_chk("rand_base", 4'h4, m_base);
      end

      // START together with CLR_DONE, then CLR_DONE alone keeps the count
      fill_start(32'h300, 32'd3, 32'h10, 32'h3, hs);
      fill_finish(32'h300, 32'd3, 32'h10, hs);
      axi_write(4'h0, 32'h2, 4'hF, 1'b0, hs);
      read_chk("clr_done", 4'h0, 32'h0003_0000);

      // START and LEN writes while busy do not disturb the running fill
      fill_start(32'h200, 32'd20, 32'h55, 32'h1, hs);
      axi_read(4'h0, d);
      check_val("busy_bits", d & 32'h3, 32'h1);
      write_reg(4'h8, 32'd3, 4'hF);
      begin
         int hs2;
         axi_write(4'h0, 32'h1, 4'hF, 1'b0, hs2);
      end
      fill_finish(32'h200, 32'd20, 32'h55, hs);
      read_chk("busy_len_reg", 4'h8, 32'd3);

      // write response backpressure blocks a second write
      axi_write(4'hC, 32'h1111_1111, 4'hF, 1'b1, hs);
      @(negedge clk);
      awaddr = 4'hC; wdata = 32'h2222_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      stall = 0;
      repeat (5) begin
         @(negedge clk);
         if (awready || wready) stall++;
      end
      check_val("bp_no_accept", stall, 32'd0);
      check_val("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      axi_write(4'hC, 32'h2222_2222, 4'hF, 1'b0, hs);
      read_chk("bp_seed", 4'hC, 32'h2222_2222);

      // read data backpressure: rdata stays stable while the register changes
      @(negedge clk);
      araddr = 4'hC; arvalid = 1'b1;
      stall = 0;
      do begin @(negedge clk); stall++; end while (!arready && stall < 20);
      @(posedge clk); #1;
      arvalid = 1'b0;
      axi_write(4'hC, 32'h3333_3333, 4'hF, 1'b0, hs);
      repeat (5) @(negedge clk);
      check_val("rbp_rvalid", {31'd0, rvalid}, 32'd1);
      check_val("rbp_rdata", rdata, 32'h2222_2222);
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      read_chk("rbp_seed", 4'hC, 32'h3333_3333);

      // reset in the middle of a long fill
      fill_start(32'h1000, 32'd100, 32'h0, 32'h1, hs);
      repeat (10) @(negedge clk);
      check_val("midfill_en", {31'd0, bram_en}, 32'd1);
      rst = 1'b1;
      #1;
      check_val("rst_abort_en", {27'd0, bram_en, bram_we}, 32'd0);
      repeat (2) @(negedge clk);
      beats.delete();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_val("rst_no_beats", beats.size(), 32'd0);
      read_chk("rst2_ctrl", 4'h0, 32'd0);
      read_chk("rst2_base", 4'h4, 32'd0);
      read_chk("rst2_len",  4'h8, 32'd0);
      read_chk("rst2_seed", 4'hC, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
